// File: rtl/hamming_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : hamming_apb_initiator
// Function : Single-outstanding APB initiator that turns a valid/ready command
//            into an APB transfer to slave 0 (encoder) or slave 1 (decoder).
// Revision : 1.0 - initial release
// ============================================================================
module hamming_apb_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SLV_SEL_BIT    = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [1:0]  PREADY,
  input  logic [1:0]  PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_sel;
  logic [7:0]  r_wait;

  logic        w_ready;
  logic        w_slverr;
  logic [31:0] w_rdata;

  // Only the addressed slave's response lines are ever looked at.
  assign w_ready   = r_sel ? PREADY[1]  : PREADY[0];
  assign w_slverr  = r_sel ? PSLVERR[1] : PSLVERR[0];
  assign w_rdata   = r_sel ? PRDATA1    : PRDATA0;

  assign cmd_ready = (r_state == S_IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_wait      <= 8'd0;
      PADDR       <= 32'd0;
      PSEL        <= 2'b00;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_wdata;
            r_sel   <= cmd_addr[SLV_SEL_BIT];
            PSEL    <= cmd_addr[SLV_SEL_BIT] ? 2'b10 : 2'b01;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_wait  <= 8'd0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_ready) begin
            rsp_rdata   <= PWRITE ? 32'd0 : w_rdata;
            rsp_slverr  <= w_slverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 2'b00;
            PENABLE     <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_wait == c_wait_last) begin
            // Ready still low on the last allowed ACCESS cycle: abort.
            rsp_rdata   <= 32'd0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 2'b00;
            PENABLE     <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_apb_initiator
// Function : Self-checking bench for hamming_apb_initiator (table, random, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_apb_initiator;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [1:0]  PREADY;
  logic [1:0]  PSLVERR;

  int total = 0;
  int bad   = 0;

  hamming_apb_initiator #(
    .TIMEOUT_CYCLES (TO),
    .SLV_SEL_BIT    (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA0     (PRDATA0),
    .PRDATA1     (PRDATA1),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // waits = wait cycles before the selected slave raises PREADY (>= TO: never)
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_slverr;
    logic        e_timeout;
    int          e_acc;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    r           = v;
    r.e_timeout = (v.waits >= TO);
    r.e_acc     = r.e_timeout ? TO : v.waits + 1;
    r.e_rdata   = (r.e_timeout || v.write) ? 32'd0 : v.prdata;
    r.e_slverr  = r.e_timeout ? 1'b0 : v.slverr;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v);
    logic        sel;
    logic [1:0]  esel;
    logic        rdy;
    logic [31:0] prd;
    logic [31:0] held;
    sel  = v.addr[8];
    esel = sel ? 2'b10 : 2'b01;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    rsp_ready = 1'b0;
    check("cmd_ready_idle", cmd_ready, 1);
    step();
    // Keep a scrambled command on the bus: it must be ignored until IDLE.
    cmd_write = ~v.write;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    check("setup_psel", PSEL, esel);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.write);
    check("setup_pwdata", PWDATA, v.wdata);
    check("setup_cmd_ready", cmd_ready, 0);
    step();
    for (int c = 0; c < v.e_acc; c++) begin
      check("access_penable", PENABLE, 1);
      check("access_psel", PSEL, esel);
      check("access_paddr", PADDR, v.addr);
      check("access_rsp_valid", rsp_valid, 0);
      rdy     = (c == v.waits);
      prd     = rdy ? v.prdata : $urandom;
      PREADY  = sel ? {rdy, 1'b1} : {1'b1, rdy};
      PSLVERR = sel ? {v.slverr, 1'b1} : {1'b1, v.slverr};
      PRDATA0 = sel ? ~v.prdata : prd;
      PRDATA1 = sel ? prd : ~v.prdata;
      step();
    end
    PREADY  = 2'b00;
    PSLVERR = 2'b00;
    check("resp_valid", rsp_valid, 1);
    check("resp_psel", PSEL, 0);
    check("resp_penable", PENABLE, 0);
    check("resp_rdata", rsp_rdata, v.e_rdata);
    check("resp_slverr", rsp_slverr, v.e_slverr);
    check("resp_timeout", rsp_timeout, v.e_timeout);
    check("resp_cmd_ready", cmd_ready, 0);
    held = rsp_rdata;
    for (int h = 0; h < v.hold; h++) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_paddr_held", PADDR, v.addr);
  endtask

  initial begin
    vec_t v;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b0;
    PRDATA0   = 32'd0;
    PRDATA1   = 32'd0;
    PREADY    = 2'b00;
    PSLVERR   = 2'b00;

    //          wr    addr          wdata         waits  prdata        err   hold e_rdata       e_err e_to  e_acc
    tbl[0] = '{1'b1, 32'h0000_0000, 32'h0000_00A5, 0,     32'h0,        1'b0, 0,   32'h0,        1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h0000_0100, 32'h0,         3,     32'h0000_0B5A, 1'b0, 0,  32'h0000_0B5A, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b0, 32'h0000_0000, 32'h0,         NEVER, 32'h77,       1'b0, 0,   32'h0,        1'b0, 1'b1, 16};
    tbl[3] = '{1'b0, 32'h0000_0104, 32'h0,         2,     32'h1234,     1'b1, 1,   32'h1234,     1'b1, 1'b0, 3};
    tbl[4] = '{1'b0, 32'h0000_0008, 32'h0,         0,     32'hDEADBEEF, 1'b0, 5,   32'hDEADBEEF, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b0, 32'h0000_01FC, 32'h0,         15,    32'h55,       1'b0, 0,   32'h55,       1'b0, 1'b0, 16};
    tbl[6] = '{1'b1, 32'h0000_01F0, 32'h12345678,  1,     32'hFFFF,     1'b1, 2,   32'h0,        1'b1, 1'b0, 2};
    tbl[7] = '{1'b0, 32'h0000_01AC, 32'h0,         NEVER, 32'h99,       1'b1, 0,   32'h0,        1'b0, 1'b1, 16};
    tbl[8] = '{1'b1, 32'h0000_00FC, 32'h0000_CAFE, 14,    32'h0,        1'b0, 0,   32'h0,        1'b0, 1'b0, 15};

    step();
    step();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_slverr", rsp_slverr, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    PRESETn = 1'b1;
    step();
    check("rel_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 9; i++) run_xfer(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      v.write  = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.waits  = $urandom_range(0, 20);
      v.prdata = $urandom;
      v.slverr = 1'($urandom_range(0, 1));
      v.hold   = $urandom_range(0, 3);
      run_xfer(ref_model(v));
    end

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0100;
    cmd_wdata = 32'd0;
    PREADY    = 2'b00;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("mid_penable", PENABLE, 1);
    check("mid_psel", PSEL, 2'b10);
    #2;
    PRESETn = 1'b0;
    #1;
    check("arst_psel", PSEL, 0);
    check("arst_penable", PENABLE, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_paddr", PADDR, 0);
    step();
    PRESETn = 1'b1;
    step();
    check("arel_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("arel_no_rsp", rsp_valid, 0);
      check("arel_psel", PSEL, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_apb_initiator.md
HAMMING_APB_INITIATOR -- requirements
Module: hamming_apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS cycles to wait for PREADY before the transfer is aborted (legal range 2..255).
REQ-002 SHALL have parameter SLV_SEL_BIT, default 8: the command-address bit that selects slave 0 (encoder) or slave 1 (decoder).
REQ-003 SHALL have port PCLK, input, 1: the single clock.
REQ-004 SHALL have port PRESETn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command request.
REQ-006 SHALL have port cmd_ready, output, 1: initiator can accept a command.
REQ-007 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, 32: transfer address.
REQ-009 SHALL have port cmd_wdata, input, 32: write data.
REQ-010 SHALL have port rsp_valid, output, 1: response available.
REQ-011 SHALL have port rsp_ready, input, 1: response consumed.
REQ-012 SHALL have port rsp_rdata, output, 32: read data; 0 for writes and for timeouts.
REQ-013 SHALL have port rsp_slverr, output, 1: the slave signalled PSLVERR.
REQ-014 SHALL have port rsp_timeout, output, 1: the transfer was aborted on timeout.
REQ-015 SHALL have port PADDR, output, 32: APB address.
REQ-016 SHALL have port PSEL, output, 2: one-hot slave select.
REQ-017 SHALL have port PENABLE, output, 1: APB enable.
REQ-018 SHALL have port PWRITE, output, 1: APB direction.
REQ-019 SHALL have port PWDATA, output, 32: APB write data.
REQ-020 SHALL have ports PRDATA0 and PRDATA1, input, 32 each: read data from slave 0 and slave 1.
REQ-021 SHALL have ports PREADY and PSLVERR, input, 2 each: bit i of each belongs to slave i.

Function
REQ-022 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-023 SHALL, in IDLE, drive cmd_ready=1; cmd_ready SHALL be 0 in every other state, so at most one transfer is ever outstanding.
REQ-024 SHALL, in IDLE, register cmd_write, cmd_addr and cmd_wdata when cmd_valid=1 and cmd_ready=1, then go to SETUP.
REQ-025 SHALL, in SETUP, drive PSEL[cmd_addr[SLV_SEL_BIT]]=1 with all other PSEL bits 0, drive PENABLE=0, drive PADDR/PWRITE/PWDATA from the registered command, clear the wait counter, and go to ACCESS next cycle.
REQ-026 SHALL, in ACCESS, drive PENABLE=1 and keep PSEL, PADDR, PWRITE and PWDATA stable until the transfer completes.
REQ-027 SHALL, in ACCESS, sample only the selected slave's PREADY, PSLVERR and PRDATA; inputs from the unselected slave SHALL be ignored.
REQ-028 SHALL, in ACCESS with selected PREADY=1: register rsp_rdata (selected PRDATA for a read, 0 for a write), register rsp_slverr=selected PSLVERR and rsp_timeout=0, drop PSEL and PENABLE to 0 on the next cycle, and go to RESP.
REQ-029 SHALL, in ACCESS with selected PREADY=0, increment the wait counter; when the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, it SHALL drop PSEL and PENABLE, set rsp_timeout=1, rsp_rdata=0 and rsp_slverr=0, and go to RESP.
REQ-030 SHALL, in RESP, drive rsp_valid=1 and hold rsp_rdata, rsp_slverr and rsp_timeout stable until rsp_ready=1, then go to IDLE on the next cycle.
REQ-031 SHALL meet this latency: cmd handshake at cycle N gives PSEL at N+1, PENABLE at N+2, and rsp_valid on the cycle after the cycle in which PREADY is sampled high.
REQ-032 SHALL keep PADDR, PWRITE and PWDATA at their last values while in IDLE and RESP.
REQ-033 SHALL ignore cmd_valid outside IDLE; the command source SHALL hold the command until cmd_ready=1.

Reset
REQ-034 SHALL, on PRESETn=0, asynchronously force the state to IDLE, the wait counter to 0, and PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_slverr and rsp_timeout to 0.
REQ-035 SHALL, on reset mid-transfer, deassert PSEL and PENABLE immediately and discard the pending response.
REQ-036 SHALL drive cmd_ready=1 on the first clock edge after PRESETn is released.

Verification
REQ-037 Write addr 0x000, data 0x0000_00A5, slave 0 with PREADY=1 at once -> PSEL=01 at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_rdata=0, rsp_slverr=0 and rsp_timeout=0.
REQ-038 Read addr 0x100, slave 1 with PREADY after 3 wait cycles and PRDATA1=0x0000_0B5A -> PSEL=10, PADDR stable during the waits, rsp_rdata=0x0000_0B5A.
REQ-039 Read slave 0 with PREADY tied 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_timeout=1, rsp_rdata=0.
REQ-040 Read slave 1 while PREADY[0]=1 and PREADY[1]=0 -> no completion until PREADY[1]=1, and PSLVERR[1]=1 then gives rsp_slverr=1.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and cmd_ready stays 0; then back-to-back cmd_valid gets its next PSEL two cycles after the rsp handshake (IDLE accept, then SETUP).
REQ-042 PRESETn asserted during ACCESS -> PSEL=00 and PENABLE=0 asynchronously, no rsp_valid, and cmd_ready=1 after reset release.
